alu_rr_scheduler: RTL
=====================

ALU_RR_SCHEDULER -- requirements
Module: alu_rr_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 4-bit ALU (range 2..4).
REQ-002 Parameter ALU_LAT, default 4, cycles operands are held on the ALU before result capture (range 4..15).
REQ-003 clk  input  1  clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 req_a, req_b  input  4*NUM_REQ  operands, requester i in bits [4i+3:4i].
REQ-008 req_op  input  2*NUM_REQ  op code (00 add, 01 sub, 10 and, 11 or), requester i in bits [2i+1:2i].
REQ-009 alu_a, alu_b  output  4  operands driven to the shared ALU.
REQ-010 alu_op  output  2  op code driven to the shared ALU.
REQ-011 alu_result  input  4  ALU registered result.
REQ-012 alu_carry, alu_zero, alu_overflow  input  1 each  ALU registered flags.
REQ-013 rsp_valid  output  1  response valid.
REQ-014 rsp_ready  input  1  consumer accept.
REQ-015 rsp_id  output  2  index of requester owning the response.
REQ-016 rsp_result  output  4  captured result.
REQ-017 rsp_flags  output  3  captured {carry, zero, overflow}.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, HOLD, RESP; encoding 2 bits; illegal encodings SHALL return to IDLE.
REQ-020 IDLE: if any req_valid, grant one requester by round-robin, assert its req_ready for exactly that cycle, latch its a/b/op/index, go to HOLD.
REQ-021 Round-robin: search starts at index (last_grant+1) mod NUM_REQ, ascending with wrap; last_grant updates only on a grant; after reset search starts at 0.
REQ-022 req_ready SHALL be zero in HOLD and RESP; a request accepted is the transfer req_valid & req_ready.
REQ-023 alu_a/alu_b/alu_op SHALL be driven from the latched registers and remain constant from HOLD entry until the next grant.
REQ-024 HOLD: 4-bit hold counter starts at 1 on entry, increments each cycle; when counter == ALU_LAT, capture alu_result and flags into rsp registers and go to RESP.
REQ-025 Grant-to-rsp_valid latency is exactly ALU_LAT+1 cycles.
REQ-026 RESP: rsp_valid high; rsp_* stable while rsp_valid & !rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-027 No grant in the cycle a response is accepted; earliest next grant is the following cycle (IDLE).
REQ-028 Requests arriving during HOLD/RESP wait; req_valid deassertion before grant is legal and loses no state.
REQ-029 Requester index >= NUM_REQ never granted; unused req bits ignored.
REQ-030 rsp_id width fixed at 2; upper unused values never produced.

Reset
REQ-031 Asynchronous reset SHALL force: state IDLE, last_grant NUM_REQ-1, hold counter 0, latched a/b/op 0, alu_a/alu_b/alu_op 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, req_ready 0, busy 0.
REQ-032 Reset mid-HOLD or mid-RESP SHALL drop the in-flight operation with no response produced after release.
REQ-033 First grant possible on the first rising edge after rst_n deasserts.

Structure
REQ-034 Shared package alu_pkg SHALL hold the op codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR), the scheduler state typedef, and the flag bit positions.
REQ-035 Round-robin selection SHALL be a sub-module rr_pick (inputs request vector, last grant; outputs one-hot grant, index, any) reused by later arbiters.
REQ-036 Block instantiates no ALU; bench connects it to the existing 4-bit ALU.

Verification
REQ-037 Single request: req 0 a=3 b=4 op=00 -> rsp_id 0, result 7, flags 000, rsp_valid at grant+5 (ALU_LAT 4).
REQ-038 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 in order, one response each, no grant in RESP.
REQ-039 Sub borrow/zero: a=5 b=5 op=01 -> result 0, zero 1, carry 0; a=2 b=3 op=01 -> result F, carry 1.
REQ-040 Overflow: a=7 b=1 op=00 -> result 8, overflow 1; rsp_ready low 10 cycles -> rsp_* unchanged, no new grant.
REQ-041 rst_n low during HOLD with req 2 pending -> all outputs reset values; after release next grant goes to req 0 search order, no stale response.
REQ-042 Requester 3 only after grant to 3 -> next grant still 3 (wrap), alu_* stable across HOLD.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the blocks that feed it:
// op codes, scheduler state encoding and flag bit positions.
package alu_pkg;

    // ALU op codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Scheduler states; 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_RESP = 2'b10
    } sched_state_t;

    // Bit positions inside the 3-bit {carry, zero, overflow} flag word
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 0;

    // Packs the individual ALU flags into the flag word
    function automatic logic [2:0] pack_flags(input logic carry,
                                              input logic zero,
                                              input logic ovf);
        logic [2:0] flags;
        flags             = 3'b000;
        flags[FLAG_CARRY] = carry;
        flags[FLAG_ZERO]  = zero;
        flags[FLAG_OVF]   = ovf;
        return flags;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches upward from last_grant+1 with wrap and
// returns the first active request as one-hot, index and an any flag.
// Requests are padded to four slots so the wrap is a plain 2-bit add;
// padded slots are always zero and therefore never selected.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         idx,
    output logic               any
);

    logic [3:0] req_pad_s;
    logic [3:0] grant_pad_s;
    logic [1:0] cand_s;

    // Priority search starting just after the previous winner
    always_comb begin
        req_pad_s              = 4'b0000;
        req_pad_s[NUM_REQ-1:0] = req;
        grant_pad_s            = 4'b0000;
        idx                    = 2'd0;
        any                    = 1'b0;
        cand_s                 = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_grant + k[1:0];
            if (!any && req_pad_s[cand_s]) begin
                any                 = 1'b1;
                idx                 = cand_s;
                grant_pad_s[cand_s] = 1'b1;
            end else begin
                any = any;
            end
        end
        grant = grant_pad_s[NUM_REQ-1:0];
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered 4-bit ALU among up to four requesters. A granted
// request's operands are held on the ALU for ALU_LAT cycles, the result
// and flags are captured, and a response is offered until accepted.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_op,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_op,
    input  logic [3:0]             alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [3:0]             rsp_result,
    output logic [2:0]             rsp_flags,
    output logic                   busy
);

    localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);
    localparam logic [3:0] LAT_CNT  = 4'(ALU_LAT);

    sched_state_t        state_r, state_n;
    logic [1:0]          last_grant_r;
    logic [3:0]          hold_cnt_r;
    logic [3:0]          lat_a_r, lat_b_r;
    logic [1:0]          lat_op_r, lat_id_r;
    logic [1:0]          rsp_id_r;
    logic [3:0]          rsp_result_r;
    logic [2:0]          rsp_flags_r;

    logic [NUM_REQ-1:0]  pick_grant_s;
    logic [1:0]          pick_idx_s;
    logic                pick_any_s;
    logic                grant_fire_s;
    logic                capture_s;
    logic [3:0]          a_arr_s  [4];
    logic [3:0]          b_arr_s  [4];
    logic [1:0]          op_arr_s [4];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (pick_grant_s),
        .idx        (pick_idx_s),
        .any        (pick_any_s)
    );

    // Unpack per-requester operand fields; unused slots read as zero
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_arr_s[i]  = 4'd0;
            b_arr_s[i]  = 4'd0;
            op_arr_s[i] = 2'd0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr_s[i]  = req_a[4*i +: 4];
            b_arr_s[i]  = req_b[4*i +: 4];
            op_arr_s[i] = req_op[2*i +: 2];
        end
    end

    // Next-state logic with grant and capture strobes
    always_comb begin
        state_n      = state_r;
        grant_fire_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_fire_s = 1'b1;
                    state_n      = ST_HOLD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == LAT_CNT) begin
                    capture_s = 1'b1;
                    state_n   = ST_RESP;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Accept strobe: only in the granting IDLE cycle, never while in reset
    always_comb begin
        if (grant_fire_s && rst_n) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Round-robin pointer and hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= LAST_RST;
            hold_cnt_r   <= 4'd0;
        end else begin
            if (grant_fire_s) begin
                last_grant_r <= pick_idx_s;
                hold_cnt_r   <= 4'd1;
            end else if (capture_s) begin
                hold_cnt_r   <= 4'd0;
            end else if (state_r == ST_HOLD) begin
                hold_cnt_r   <= hold_cnt_r + 4'd1;
            end else begin
                hold_cnt_r   <= hold_cnt_r;
            end
        end
    end

    // Operand latch: drives the ALU and stays put until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a_r  <= 4'd0;
            lat_b_r  <= 4'd0;
            lat_op_r <= 2'd0;
            lat_id_r <= 2'd0;
        end else if (grant_fire_s) begin
            lat_a_r  <= a_arr_s[pick_idx_s];
            lat_b_r  <= b_arr_s[pick_idx_s];
            lat_op_r <= op_arr_s[pick_idx_s];
            lat_id_r <= pick_idx_s;
        end else begin
            lat_a_r  <= lat_a_r;
            lat_b_r  <= lat_b_r;
            lat_op_r <= lat_op_r;
            lat_id_r <= lat_id_r;
        end
    end

    // Response capture at the end of the hold window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_r     <= 2'd0;
            rsp_result_r <= 4'd0;
            rsp_flags_r  <= 3'd0;
        end else if (capture_s) begin
            rsp_id_r     <= lat_id_r;
            rsp_result_r <= alu_result;
            rsp_flags_r  <= pack_flags(alu_carry, alu_zero, alu_overflow);
        end else begin
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_flags_r  <= rsp_flags_r;
        end
    end

    assign alu_a      = lat_a_r;
    assign alu_b      = lat_b_r;
    assign alu_op     = lat_op_r;
    assign rsp_valid  = (state_r == ST_RESP);
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_flags  = rsp_flags_r;
    assign busy       = (state_r != ST_IDLE);

endmodule
